rv_dmem_resp: RTL and testbench
===============================

RV_DMEM_RESP -- requirements
Module: rv_dmem_resp

Interface
- REQ-001: Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data memory array; power of two.
- REQ-002: Parameter WAIT_CYCLES, default 0: stall cycles inserted per access; legal range 0-15.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: core2dmem_req_Q103H  input  t_core2mem_req  request from the memory-access stage:
  - wr_data[31:0], address[31:0]
  - wr_en, rd_en
  - byte_en[3:0]
- REQ-006: dmem_rd_data_Q104H  output  32  registered read data, aligned to Q104H.
- REQ-007: ready_Q104H  output  1  high = access complete, pipeline may advance; low = stall.
- REQ-008: misalign_err  output  1  sticky misalignment flag; present only when DMEM_MISALIGN_CHK_EN is defined.

Function
- REQ-009: Word index is address[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS.
  - address[1:0] does not select bytes; byte_en does.
- REQ-010: A write updates only the bytes whose byte_en bit is 1; byte_en=4'b0000 with wr_en=1 leaves memory unchanged but still counts as an access.
- REQ-011: A read loads the full addressed word into dmem_rd_data_Q104H; byte_en does not mask read data.
- REQ-012: dmem_rd_data_Q104H holds its last value in every cycle without a completing read.
- REQ-013: rd_en and wr_en both 1: the write is performed, no read occurs, and dmem_rd_data_Q104H holds its value.
- REQ-014: FSM states are IDLE and BUSY, with a 4-bit counter wait_cnt.
- REQ-015: IDLE:
  - ready_Q104H=1.
  - With no request, it stays IDLE.
- REQ-016: IDLE with a request (rd_en|wr_en) and WAIT_CYCLES=0:
  - The access is performed at the same edge.
  - Read data is valid the next cycle.
  - The FSM stays IDLE (1-cycle latency, full throughput).
- REQ-017: IDLE with a request and WAIT_CYCLES>0:
  - The whole request is captured into an internal register.
  - wait_cnt is loaded with WAIT_CYCLES and the FSM goes to BUSY.
  - No memory update occurs at this edge.
- REQ-018: BUSY:
  - ready_Q104H=0.
  - wait_cnt decrements each cycle.
  - Live request inputs are ignored; the captured copy is used.
- REQ-019: BUSY with wait_cnt=1: the captured access is performed at that edge and the FSM returns to IDLE.
  - ready_Q104H=1 and read data are valid the following cycle.
  - Total latency is WAIT_CYCLES+1 cycles.
- REQ-020: A new request presented in the first IDLE cycle after BUSY is accepted normally (back-to-back accesses).
- REQ-021: A read following a write to the same word in the next accepted access returns the newly written bytes.

Reset
- REQ-022: rst low, regardless of clk:
  - FSM goes to IDLE and wait_cnt is cleared.
  - ready_Q104H=1 and dmem_rd_data_Q104H=32'h0.
  - misalign_err=0 when present.
- REQ-023: A reset asserted while in BUSY discards the captured access; a pending write is never committed.
- REQ-024: Memory array contents are not reset.

Configuration
- REQ-025: Macro DMEM_MISALIGN_CHK_EN, when defined:
  - An access is misaligned when byte_en=4'b1111 with address[1:0]≠0, or byte_en∈{4'b0011, 4'b1100} with address[0]=1.
  - A misaligned write does not modify memory.
  - A misaligned read does not update dmem_rd_data_Q104H.
  - Timing and handshake are unchanged.
  - misalign_err sets at the completing edge and stays set until reset.
- REQ-026: When DMEM_MISALIGN_CHK_EN is undefined, the misalign_err port and all check logic are absent, and address[1:0] is fully ignored.

Verification
- REQ-027: WAIT_CYCLES=0: write 32'hDEADBEEF to 0x40 with byte_en=4'hF, then read 0x40 -> dmem_rd_data_Q104H=32'hDEADBEEF one cycle after the read; ready_Q104H stays 1 throughout.
- REQ-028: Word 0x40=32'hDEADBEEF: write 32'h00001200 with byte_en=4'b0010, then read -> 32'hDEAD12EF.
- REQ-029: WAIT_CYCLES=3: read 0x8 (holding 32'hA5A5A5A5) while changing the live address during the stall -> ready_Q104H low for exactly 3 cycles, then data=32'hA5A5A5A5 from the originally captured address.
- REQ-030: DEPTH_WORDS=1024: write 32'h11 to address 0x1000 -> a read of address 0x0 returns 32'h11 (wrap-around).
- REQ-031: WAIT_CYCLES=4: write 32'hFFFFFFFF to 0x20, then assert rst 2 cycles into BUSY -> ready_Q104H=1 and rd_data=0 immediately; a later read of 0x20 returns the pre-write value.
- REQ-032: With DMEM_MISALIGN_CHK_EN defined: write byte_en=4'hF to 0x42 -> memory unchanged and misalign_err=1 until reset.

Source files
------------

// File: rtl/rv_dmem_resp_if.sv
// Request bundle type and core<->dmem handshake interface.
// Optional misalign_err signal exists only with DMEM_MISALIGN_CHK_EN.
package rv_dmem_pkg;
  typedef struct packed {
    logic [31:0] wr_data;
    logic [31:0] address;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;
endpackage

interface rv_dmem_resp_if;
  import rv_dmem_pkg::*;
  t_core2mem_req core2dmem_req_Q103H;
  logic [31:0]   dmem_rd_data_Q104H;
  logic          ready_Q104H;
`ifdef DMEM_MISALIGN_CHK_EN
  logic          misalign_err;
  modport master (
    output core2dmem_req_Q103H,
    input  dmem_rd_data_Q104H,
    input  ready_Q104H,
    input  misalign_err
  );
  modport slave (
    input  core2dmem_req_Q103H,
    output dmem_rd_data_Q104H,
    output ready_Q104H,
    output misalign_err
  );
`else
  modport master (
    output core2dmem_req_Q103H,
    input  dmem_rd_data_Q104H,
    input  ready_Q104H
  );
  modport slave (
    input  core2dmem_req_Q103H,
    output dmem_rd_data_Q104H,
    output ready_Q104H
  );
`endif
endinterface

// File: rtl/rv_dmem_resp.sv
// Data memory with byte-enable writes, optional wait states.
// Ports: clk, rst (async, active low), bus (slave: req in,
// rd_data/ready out, misalign_err if DMEM_MISALIGN_CHK_EN).
module rv_dmem_resp
  import rv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  rv_dmem_resp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt, cnt_d;
  t_core2mem_req req_q, acc_req;
  logic          cap_en;
  logic          acc_go;
  logic          ok;
  logic          wr_go, rd_go;
  logic [AW-1:0] idx;
  logic [31:0]   rd_data_q;
  logic [31:0]   mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = wait_cnt;
    cap_en  = 1'b0;
    acc_go  = 1'b0;
    acc_req = bus.core2dmem_req_Q103H;
    unique case (state_q)
      IDLE: begin
        if (bus.core2dmem_req_Q103H.rd_en ||
            bus.core2dmem_req_Q103H.wr_en) begin
          if (WAIT_CYCLES == 0) begin
            acc_go = 1'b1;
          end else begin
            cap_en  = 1'b1;
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_req = req_q;
        cnt_d   = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          acc_go  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q;

  assign ok =
    !((acc_req.byte_en == 4'b1111 &&
       acc_req.address[1:0] != 2'b00) ||
      ((acc_req.byte_en == 4'b0011 ||
        acc_req.byte_en == 4'b1100) &&
       acc_req.address[0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else if (acc_go && !ok) misalign_q <= 1'b1;
  end

  assign bus.misalign_err = misalign_q;
`else
  assign ok = 1'b1;
`endif

  // Gate on rst so a clock edge during reset never commits.
  assign wr_go = acc_go & rst & ok & acc_req.wr_en;
  assign rd_go = acc_go & rst & ok & acc_req.rd_en &
                 ~acc_req.wr_en;
  assign idx   = acc_req.address[AW+1:2];

  logic unused_addr;
  assign unused_addr = ^{acc_req.address[31:AW+2],
                         acc_req.address[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wait_cnt  <= '0;
      req_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= cnt_d;
      if (cap_en) req_q <= bus.core2dmem_req_Q103H;
      if (rd_go) rd_data_q <= mem[idx];
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_req.byte_en[b])
          mem[idx][8*b +: 8] <= acc_req.wr_data[8*b +: 8];
      end
    end
  end

  assign bus.dmem_rd_data_Q104H = rd_data_q;
  assign bus.ready_Q104H        = (state_q == IDLE);
endmodule

// File: tb/tb_rv_dmem_resp.sv
// Scoreboard bench for rv_dmem_resp: three instances with
// WAIT_CYCLES 0, 3 and 4 sharing clk and rst.
module tb_rv_dmem_resp;
  import rv_dmem_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  t_core2mem_req req   [3];
  logic          ready [3];
  logic [31:0]   rdata [3];
`ifdef DMEM_MISALIGN_CHK_EN
  logic          merr  [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    rv_dmem_resp_if ifc ();
    assign ifc.core2dmem_req_Q103H = req[g];
    assign ready[g] = ifc.ready_Q104H;
    assign rdata[g] = ifc.dmem_rd_data_Q104H;
`ifdef DMEM_MISALIGN_CHK_EN
    assign merr[g] = ifc.misalign_err;
`endif
    rv_dmem_resp #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 4))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  typedef struct {
    int          d;
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  function automatic void push(int d, string n,
                               logic [31:0] v);
    exp_t e;
    e.d = d;
    e.name = n;
    e.data = v;
    sbq.push_back(e);
  endfunction

  // Monitor: a read accepted at a rising edge completes when
  // ready is seen high on a later falling edge.
  initial begin
    bit   pend [3];
    exp_t e;
    for (int d = 0; d < 3; d++) pend[d] = 1'b0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst) pend[d] = 1'b0;
        else if (ready[d] && req[d].rd_en && !req[d].wr_en)
          pend[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (pend[d] && ready[d]) begin
          pend[d] = 1'b0;
          if (sbq.size() == 0) begin
            chk("sb_unexpected_read", rdata[d], 32'hx);
          end else begin
            e = sbq.pop_front();
            chk("sb_dut_id", 32'(d), 32'(e.d));
            chk(e.name, rdata[d], e.data);
          end
        end
      end
    end
  end

  task automatic acc(input int d, input logic w,
                     input logic r, input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] be, input bit scr,
                     output int st);
    int to;
    @(negedge clk);
    req[d] = '{wr_data: wd, address: a, wr_en: w,
               rd_en: r, byte_en: be};
    to = 0;
    @(posedge clk);
    while (!ready[d] && to < 64) begin
      to++;
      @(posedge clk);
    end
    if (to >= 64) chk("accept_timeout", 32'(to), 32'd0);
    @(negedge clk);
    st = 0;
    while (!ready[d] && st < 64) begin
      if (scr) req[d].address = a ^ 32'h0000_0104;
      st++;
      @(negedge clk);
    end
    if (st >= 64) chk("complete_timeout", 32'(st), 32'd0);
    req[d] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int st;
    logic [31:0] last;
    for (int d = 0; d < 3; d++) req[d] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(ready[d]), 32'd1);
      chk("reset_rdata", rdata[d], 32'h0);
    end
    rst = 1'b1;

    // No wait states
    acc(0, 1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0, st);
    chk("w0_write_stall", 32'(st), 32'd0);
    push(0, "w0_read_full", 32'hDEADBEEF);
    acc(0, 0, 1, 32'h40, 32'h0, 4'hF, 0, st);
    chk("w0_read_stall", 32'(st), 32'd0);
    acc(0, 1, 0, 32'h40, 32'h00001200, 4'b0010, 0, st);
    push(0, "w0_byte1_merge", 32'hDEAD12EF);
    acc(0, 0, 1, 32'h40, 32'h0, 4'hF, 0, st);
    acc(0, 1, 0, 32'h1000, 32'h11, 4'hF, 0, st);
    push(0, "w0_wrap", 32'h11);
    acc(0, 0, 1, 32'h0, 32'h0, 4'hF, 0, st);
    acc(0, 1, 0, 32'h40, 32'h0, 4'h0, 0, st);
    push(0, "w0_be_zero", 32'hDEAD12EF);
    acc(0, 0, 1, 32'h40, 32'h0, 4'hF, 0, st);
    acc(0, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, st);
    chk("w0_rdwr_hold", rdata[0], 32'hDEAD12EF);
    push(0, "w0_read_nomask", 32'hCAFEF00D);
    acc(0, 0, 1, 32'h40, 32'h0, 4'b0001, 0, st);

    // Full-word write at a non-aligned address
    acc(0, 1, 0, 32'h42, 32'h0BADF00D, 4'hF, 0, st);
`ifdef DMEM_MISALIGN_CHK_EN
    last = 32'hCAFEF00D;
    chk("misalign_flag", 32'(merr[0]), 32'd1);
`else
    last = 32'h0BADF00D;
`endif
    push(0, "w0_after_unaligned_wr", last);
    acc(0, 0, 1, 32'h40, 32'h0, 4'hF, 0, st);
    push(0, "w0_unaligned_rd", last);
    acc(0, 0, 1, 32'h41, 32'h0, 4'b0011, 0, st);

    // Three wait states
    acc(1, 1, 0, 32'h8, 32'hA5A5A5A5, 4'hF, 0, st);
    chk("w3_write_stall", 32'(st), 32'd3);
    acc(1, 1, 0, 32'hC, 32'h5A5A5A5A, 4'hF, 0, st);
    push(1, "w3_captured_addr", 32'hA5A5A5A5);
    acc(1, 0, 1, 32'h8, 32'h0, 4'hF, 1, st);
    chk("w3_read_stall", 32'(st), 32'd3);
    push(1, "w3_second_word", 32'h5A5A5A5A);
    acc(1, 0, 1, 32'hC, 32'h0, 4'hF, 0, st);

    // Four wait states, reset during BUSY
    acc(2, 1, 0, 32'h20, 32'h12345678, 4'hF, 0, st);
    chk("w4_write_stall", 32'(st), 32'd4);
    push(2, "w4_pre_reset_rd", 32'h12345678);
    acc(2, 0, 1, 32'h20, 32'h0, 4'hF, 0, st);
    @(negedge clk);
    req[2] = '{wr_data: 32'hFFFFFFFF, address: 32'h20,
               wr_en: 1'b1, rd_en: 1'b0, byte_en: 4'hF};
    @(posedge clk);
    @(negedge clk);
    req[2] = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("w4_busy_before_rst", 32'(ready[2]), 32'd0);
    rst = 1'b0;
    #1;
    chk("w4_rst_ready", 32'(ready[2]), 32'd1);
    chk("w4_rst_rdata", rdata[2], 32'h0);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign_rst", 32'(merr[0]), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    push(2, "w4_write_discarded", 32'h12345678);
    acc(2, 0, 1, 32'h20, 32'h0, 4'hF, 0, st);
    chk("w4_read_stall", 32'(st), 32'd4);

    repeat (4) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({"sb_missing_", e.name}, 32'hx, e.data);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end
endmodule
